// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the SRAM access controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int SRAM_DW = 16;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  function automatic logic [31:0] word_of(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction
endpackage

// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: CPU request side and 16-bit SRAM bus of the access controller
interface sram_access_ctrl_if #(parameter int SRAM_AW = 18);
  import mem_ctrl_pkg::*;
  logic rd_en;
  logic wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic sram_dq_oe;
  logic sram_we_n;
  modport master (
    output rd_en, wr_en, address, wdata, sram_dq_in,
    input rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport slave (
    input rd_en, wr_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: splits 32-bit loads/stores into two wait-stated 16-bit SRAM accesses
module sram_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 18,
  parameter int WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input logic clk,
  input logic rst,
  sram_access_ctrl_if.slave bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic op_wr;
  logic [31:0] addr_q;
  logic [15:0] wdata_hi_q;
  logic [31:0] rdata_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [SRAM_DW-1:0] dq_out_q;
  logic [SRAM_AW-2:0] word_in, word_q;
  logic req, busy, last;
  assign req = bus.rd_en | bus.wr_en;
  assign busy = (state == LO) || (state == HI);
  assign last = cnt == LAST;
  assign word_in = (SRAM_AW-1)'(word_of(bus.address, BASE_ADDR));
  assign word_q = (SRAM_AW-1)'(word_of(addr_q, BASE_ADDR));
  // next state: one pass through LO then HI, DONE lasts a single cycle
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = req ? LO : IDLE;
      LO: state_d = last ? HI : LO;
      HI: state_d = last ? DONE : HI;
      default: state_d = IDLE;
    endcase
  end
  // state register and per-half wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= (busy && !last) ? cnt + 1'b1 : '0;
    end
  end
  // request latch, SRAM address/data per half, and read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr <= 1'b0;
      addr_q <= '0;
      wdata_hi_q <= '0;
      rdata_q <= '0;
      sram_addr_q <= '0;
      dq_out_q <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr <= bus.wr_en;
        addr_q <= bus.address;
        wdata_hi_q <= bus.wdata[31:16];
        sram_addr_q <= {word_in, 1'b0};
        dq_out_q <= bus.wdata[15:0];
      end
      if (state == LO && last) begin
        sram_addr_q <= {word_q, 1'b1};
        dq_out_q <= wdata_hi_q;
      end
      if (state == LO && last && !op_wr) rdata_q[15:0] <= bus.sram_dq_in;
      if (state == HI && last && !op_wr) rdata_q[31:16] <= bus.sram_dq_in;
    end
  end
  assign bus.ready = (state == IDLE) ? ~req : (state == DONE);
  assign bus.rdata = rdata_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe = busy & op_wr;
  assign bus.sram_we_n = ~(busy & op_wr & (!last || WAIT_CYCLES == 1));
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed checks of the SRAM access controller at W=2 and W=1
module tb_sram_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  sram_access_ctrl_if #(.SRAM_AW(18)) a();
  sram_access_ctrl_if #(.SRAM_AW(18)) b();
  sram_access_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  sram_access_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  assign a.sram_dq_in = mem_a[a.sram_addr[5:0]];
  assign b.sram_dq_in = mem_b[b.sram_addr[5:0]];
  always @(posedge clk) begin
    if (a.sram_dq_oe && !a.sram_we_n) mem_a[a.sram_addr[5:0]] <= a.sram_dq_out;
    if (b.sram_dq_oe && !b.sram_we_n) mem_b[b.sram_addr[5:0]] <= b.sram_dq_out;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_b[2] = 16'h1111;
    mem_b[3] = 16'h2222;
    mem_b[4] = 16'h3333;
    mem_b[5] = 16'h4444;
    rst = 1'b1;
    a.rd_en = 1'b1; a.wr_en = 1'b0; a.address = 32'd1028; a.wdata = '0;
    b.rd_en = 1'b0; b.wr_en = 1'b0; b.address = '0; b.wdata = '0;
    #2;
    chk("rst_we_n", a.sram_we_n, 1);
    chk("rst_oe", a.sram_dq_oe, 0);
    chk("rst_rdata", a.rdata, 0);
    cyc(); rst = 1'b0; #1;
    chk("rst_ready_req", a.ready, 0);
    a.rd_en = 1'b0; #1;
    chk("idle_ready", a.ready, 1);
    // store 0xDEADBEEF @1028, W=2
    cyc(); a.wr_en = 1'b1; a.address = 32'd1028; a.wdata = 32'hDEADBEEF; #1;
    chk("st_c0_ready", a.ready, 0);
    cyc(); a.wr_en = 1'b0; a.address = '0; a.wdata = '0; #1;
    chk("st_c1_ready", a.ready, 0);
    chk("st_c1_addr", a.sram_addr, 2);
    chk("st_c1_dq", a.sram_dq_out, 16'hBEEF);
    chk("st_c1_oe", a.sram_dq_oe, 1);
    chk("st_c1_we_n", a.sram_we_n, 0);
    cyc(); #1;
    chk("st_c2_ready", a.ready, 0);
    chk("st_c2_addr", a.sram_addr, 2);
    chk("st_c2_we_n", a.sram_we_n, 1);
    cyc(); #1;
    chk("st_c3_ready", a.ready, 0);
    chk("st_c3_addr", a.sram_addr, 3);
    chk("st_c3_dq", a.sram_dq_out, 16'hDEAD);
    chk("st_c3_we_n", a.sram_we_n, 0);
    cyc(); #1;
    chk("st_c4_ready", a.ready, 0);
    chk("st_c4_we_n", a.sram_we_n, 1);
    cyc(); #1;
    chk("st_done_ready", a.ready, 1);
    chk("st_done_oe", a.sram_dq_oe, 0);
    chk("st_done_we_n", a.sram_we_n, 1);
    chk("st_done_addr_hold", a.sram_addr, 3);
    chk("st_mem2", mem_a[2], 16'hBEEF);
    chk("st_mem3", mem_a[3], 16'hDEAD);
    // load @1028; rd_en dropped and address changed mid-access
    cyc(); a.rd_en = 1'b1; a.address = 32'd1028; #1;
    chk("ld_c0_ready", a.ready, 0);
    cyc(); a.rd_en = 1'b0; a.address = 32'd2000; #1;
    chk("ld_c1_ready", a.ready, 0);
    chk("ld_c1_oe", a.sram_dq_oe, 0);
    chk("ld_c1_we_n", a.sram_we_n, 1);
    chk("ld_c1_addr", a.sram_addr, 2);
    cyc(); #1;
    chk("ld_c2_ready", a.ready, 0);
    cyc(); #1;
    chk("ld_c3_addr", a.sram_addr, 3);
    chk("ld_c3_ready", a.ready, 0);
    cyc(); #1;
    chk("ld_c4_ready", a.ready, 0);
    cyc(); #1;
    chk("ld_done_ready", a.ready, 1);
    chk("ld_done_rdata", a.rdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("ld_idle_ready", a.ready, 1);
    chk("ld_rdata_held", a.rdata, 32'hDEADBEEF);
    // rd_en and wr_en together: write wins
    a.rd_en = 1'b1; a.wr_en = 1'b1; a.address = 32'd1032; a.wdata = 32'h12345678; #1;
    chk("both_c0_ready", a.ready, 0);
    cyc(); a.rd_en = 1'b0; a.wr_en = 1'b0; #1;
    chk("both_c1_oe", a.sram_dq_oe, 1);
    chk("both_c1_we_n", a.sram_we_n, 0);
    chk("both_c1_addr", a.sram_addr, 4);
    chk("both_c1_dq", a.sram_dq_out, 16'h5678);
    cyc(); cyc(); cyc(); cyc(); #1;
    chk("both_done_ready", a.ready, 1);
    chk("both_rdata_kept", a.rdata, 32'hDEADBEEF);
    chk("both_mem4", mem_a[4], 16'h5678);
    chk("both_mem5", mem_a[5], 16'h1234);
    // reset during HI of a store
    cyc(); a.wr_en = 1'b1; a.address = 32'd1036; a.wdata = 32'hAAAA5555; #1;
    cyc(); a.wr_en = 1'b0; #1;
    cyc(); cyc(); #1;
    chk("rhi_we_n_pre", a.sram_we_n, 0);
    chk("rhi_addr_pre", a.sram_addr, 7);
    rst = 1'b1; #1;
    chk("rhi_we_n", a.sram_we_n, 1);
    chk("rhi_oe", a.sram_dq_oe, 0);
    chk("rhi_ready", a.ready, 1);
    chk("rhi_addr", a.sram_addr, 0);
    cyc(); rst = 1'b0; #1;
    chk("rhi_mem6", mem_a[6], 16'h5555);
    chk("rhi_mem7", mem_a[7], 16'h0000);
    chk("rhi_idle_ready", a.ready, 1);
    // back-to-back loads at W=1
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) begin b.rd_en = 1'b1; b.address = 32'd1028; end
      if (i == 3) b.address = 32'd1032;
      if (i == 7) b.rd_en = 1'b0;
      #1;
      chk($sformatf("b2b_ready_%0d", i), b.ready, (i == 3 || i == 7) ? 1 : 0);
      if (i == 3) chk("b2b_rdata_1", b.rdata, 32'h22221111);
      if (i == 7) chk("b2b_rdata_2", b.rdata, 32'h44443333);
    end
    cyc(); #1;
    chk("b2b_idle_ready", b.ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
